// File: rtl/wm_panel_ctrl_if.sv
// Front-panel bundle between the raw panel/wash FSM side and wm_panel_ctrl.
// start is a one-cycle request and program_done a one-cycle acknowledgement; busy spans the pair.
interface wm_panel_ctrl_if;
    logic       power;
    logic       btn_prog_raw;
    logic       btn_start_raw;
    logic       door_sw_raw;
    logic       soap_sw_raw;
    logic       program_done;
    logic [2:0] program_selection;
    logic       start;
    logic       doorclosed;
    logic       soap;
    logic       door_lock;
    logic       busy;
    logic [2:0] dbg_state;

    modport slave (
        input  power, btn_prog_raw, btn_start_raw, door_sw_raw, soap_sw_raw, program_done,
        output program_selection, start, doorclosed, soap, door_lock, busy, dbg_state
    );

    modport master (
        output power, btn_prog_raw, btn_start_raw, door_sw_raw, soap_sw_raw, program_done,
        input  program_selection, start, doorclosed, soap, door_lock, busy, dbg_state
    );
endinterface

// File: rtl/wm_panel_ctrl.sv
// Panel input conditioner (sync + debounce) and door-lock/start sequencer for the wash FSM.
// All outputs come straight from flops; dbg_state mirrors the sequencer state.
module wm_panel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCK_DELAY      = 3,
    parameter int NUM_PROGRAMS    = 4
) (
    input logic         clk,
    input logic         rst,
    wm_panel_ctrl_if.slave bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LOCK_DELAY + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_DELAY);
    localparam logic [LW-1:0] LOCK_ONE  = LW'(1);
    localparam logic [2:0]    SEL_LAST  = 3'(NUM_PROGRAMS - 1);

    // Channel order: 0 = prog button, 1 = start button, 2 = door, 3 = soap
    localparam int CH_PROG  = 0;
    localparam int CH_START = 1;
    localparam int CH_DOOR  = 2;
    localparam int CH_SOAP  = 3;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        SELECT  = 3'd1,
        LOCKING = 3'd2,
        RUN_REQ = 3'd3,
        RUNNING = 3'd4
    } state_t;

    logic [3:0]    raw;
    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    db_q;
    logic [CW-1:0] db_cnt_q [4];
    logic [1:0]    btn_prev_q;

    state_t        state_q;
    logic [2:0]    sel_q;
    logic [2:0]    sel_next_d;
    logic [LW-1:0] lock_cnt_q;
    logic          start_q;
    logic          lock_q;
    logic          busy_q;
    logic          prog_press;
    logic          start_press;

    assign raw = {bus.soap_sw_raw, bus.door_sw_raw, bus.btn_start_raw, bus.btn_prog_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            btn_prev_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            btn_prev_q <= db_q[1:0];
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    // This is the DEBOUNCE_CYCLES-th differing sample: commit it.
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign prog_press  = db_q[CH_PROG]  & ~btn_prev_q[CH_PROG];
    assign start_press = db_q[CH_START] & ~btn_prev_q[CH_START];
    assign sel_next_d  = (sel_q >= SEL_LAST) ? 3'd0 : sel_q + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OFF;
            sel_q      <= '0;
            lock_cnt_q <= '0;
            start_q    <= 1'b0;
            lock_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else if (!bus.power) begin
            // Power loss overrides every other transition.
            state_q    <= OFF;
            sel_q      <= '0;
            lock_cnt_q <= '0;
            start_q    <= 1'b0;
            lock_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    state_q <= SELECT;
                end
                SELECT: begin
                    if (start_press && db_q[CH_DOOR]) begin
                        state_q    <= LOCKING;
                        lock_cnt_q <= LOCK_LOAD;
                        lock_q     <= 1'b1;
                    end else if (prog_press) begin
                        sel_q <= sel_next_d;
                    end
                end
                LOCKING: begin
                    if (!db_q[CH_DOOR]) begin
                        state_q    <= SELECT;
                        lock_cnt_q <= '0;
                        lock_q     <= 1'b0;
                    end else if (lock_cnt_q == LOCK_ONE) begin
                        state_q    <= RUN_REQ;
                        lock_cnt_q <= '0;
                        start_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q - 1'b1;
                    end
                end
                RUN_REQ: begin
                    state_q <= RUNNING;
                    start_q <= 1'b0;
                end
                RUNNING: begin
                    if (bus.program_done) begin
                        state_q <= SELECT;
                        lock_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= OFF;
                    sel_q      <= '0;
                    lock_cnt_q <= '0;
                    start_q    <= 1'b0;
                    lock_q     <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.program_selection = sel_q;
    assign bus.start             = start_q;
    assign bus.doorclosed        = db_q[CH_DOOR];
    assign bus.soap              = db_q[CH_SOAP];
    assign bus.door_lock         = lock_q;
    assign bus.busy              = busy_q;
    assign bus.dbg_state         = state_q;

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Directed bench for wm_panel_ctrl with default parameters (debounce 4, lock delay 3, 4 programs).
module tb_wm_panel_ctrl;

    localparam logic [2:0] ST_OFF     = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_RUNNING = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [2:0] exp_q[$];

    wm_panel_ctrl_if bus();

    wm_panel_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clean press: hold 8 edges (press acts at edge 7), release 8 edges.
    task automatic press(input int which);
        if (which == 0) bus.btn_prog_raw = 1'b1; else bus.btn_start_raw = 1'b1;
        step(8);
        if (which == 0) bus.btn_prog_raw = 1'b0; else bus.btn_start_raw = 1'b0;
        step(8);
    endtask

    task automatic test_reset;
        step(3);
        checks++; if (bus.program_selection !== 3'd0) begin failures++; $display("FAIL reset_sel: got %0d expected 0", bus.program_selection); end
        checks++; if (bus.start !== 1'b0) begin failures++; $display("FAIL reset_start: got %0b expected 0", bus.start); end
        checks++; if (bus.door_lock !== 1'b0) begin failures++; $display("FAIL reset_lock: got %0b expected 0", bus.door_lock); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        checks++; if (bus.doorclosed !== 1'b0 || bus.soap !== 1'b0) begin failures++; $display("FAIL reset_switches: got door=%0b soap=%0b expected 0 0", bus.doorclosed, bus.soap); end
        checks++; if (bus.dbg_state !== ST_OFF) begin failures++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, ST_OFF); end
        rst = 1'b0;
        step(2);
        checks++; if (bus.dbg_state !== ST_OFF) begin failures++; $display("FAIL off_no_power: got %0d expected %0d", bus.dbg_state, ST_OFF); end
    endtask

    task automatic test_soap;
        bus.soap_sw_raw = 1'b1;
        step(5);
        checks++; if (bus.soap !== 1'b0) begin failures++; $display("FAIL soap_early: got %0b expected 0", bus.soap); end
        step(1);
        checks++; if (bus.soap !== 1'b1) begin failures++; $display("FAIL soap_edge6: got %0b expected 1", bus.soap); end
        bus.power = 1'b1;
        step(1);
        checks++; if (bus.dbg_state !== ST_SELECT) begin failures++; $display("FAIL power_on: got %0d expected %0d", bus.dbg_state, ST_SELECT); end
    endtask

    task automatic test_debounce_glitch;
        for (int i = 0; i < 20; i++) begin
            bus.btn_prog_raw = ~bus.btn_prog_raw;
            step(1);
        end
        bus.btn_prog_raw = 1'b0;
        step(10);
        checks++; if (bus.program_selection !== 3'd0) begin failures++; $display("FAIL glitch_sel: got %0d expected 0", bus.program_selection); end
    endtask

    task automatic test_clean_press;
        bus.btn_prog_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k == 6) begin
                checks++; if (bus.program_selection !== 3'd0) begin failures++; $display("FAIL press_edge6: got %0d expected 0", bus.program_selection); end
            end
            if (k == 7) begin
                checks++; if (bus.program_selection !== 3'd1) begin failures++; $display("FAIL press_edge7: got %0d expected 1", bus.program_selection); end
            end
        end
        checks++; if (bus.program_selection !== 3'd1) begin failures++; $display("FAIL press_held: got %0d expected 1", bus.program_selection); end
        bus.btn_prog_raw = 1'b0;
        step(8);
    endtask

    task automatic test_wrap;
        logic [2:0] exp;
        bus.power = 1'b0;
        step(1);
        checks++; if (bus.program_selection !== 3'd0 || bus.dbg_state !== ST_OFF) begin failures++; $display("FAIL power_off_sel: got sel=%0d state=%0d expected 0 0", bus.program_selection, bus.dbg_state); end
        bus.power = 1'b1;
        step(1);
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
        while (exp_q.size() > 0) begin
            press(0);
            exp = exp_q.pop_front();
            checks++; if (bus.program_selection !== exp) begin failures++; $display("FAIL wrap_sel: got %0d expected %0d", bus.program_selection, exp); end
        end
    endtask

    task automatic test_start_door_open;
        logic start_seen = 1'b0;
        logic lock_seen = 1'b0;
        checks++; if (bus.doorclosed !== 1'b0) begin failures++; $display("FAIL door_open_level: got %0b expected 0", bus.doorclosed); end
        bus.btn_start_raw = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (k == 8) bus.btn_start_raw = 1'b0;
            if (bus.start === 1'b1) start_seen = 1'b1;
            if (bus.door_lock === 1'b1) lock_seen = 1'b1;
        end
        checks++; if (start_seen !== 1'b0) begin failures++; $display("FAIL open_start: got %0b expected 0", start_seen); end
        checks++; if (lock_seen !== 1'b0) begin failures++; $display("FAIL open_lock: got %0b expected 0", lock_seen); end
        checks++; if (bus.dbg_state !== ST_SELECT) begin failures++; $display("FAIL open_state: got %0d expected %0d", bus.dbg_state, ST_SELECT); end
    endtask

    task automatic test_start_run;
        int lock_edge = 0;
        int start_edge = 0;
        int start_cnt = 0;
        press(0);
        checks++; if (bus.program_selection !== 3'd2) begin failures++; $display("FAIL run_presel: got %0d expected 2", bus.program_selection); end
        bus.door_sw_raw = 1'b1;
        step(8);
        checks++; if (bus.doorclosed !== 1'b1) begin failures++; $display("FAIL door_closed_level: got %0b expected 1", bus.doorclosed); end
        bus.btn_start_raw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            if (k == 8) bus.btn_start_raw = 1'b0;
            if (bus.door_lock === 1'b1 && lock_edge == 0) lock_edge = k;
            if (bus.start === 1'b1) begin
                start_cnt++;
                if (start_edge == 0) start_edge = k;
            end
        end
        checks++; if (lock_edge != 7) begin failures++; $display("FAIL lock_rise_edge: got %0d expected 7", lock_edge); end
        checks++; if (start_edge != 10) begin failures++; $display("FAIL start_edge: got %0d expected 10", start_edge); end
        checks++; if (start_cnt != 1) begin failures++; $display("FAIL start_count: got %0d expected 1", start_cnt); end
        checks++; if (bus.busy !== 1'b1 || bus.dbg_state !== ST_RUNNING) begin failures++; $display("FAIL running: got busy=%0b state=%0d expected 1 %0d", bus.busy, bus.dbg_state, ST_RUNNING); end
        press(0);
        checks++; if (bus.program_selection !== 3'd2) begin failures++; $display("FAIL frozen_sel: got %0d expected 2", bus.program_selection); end
        bus.door_sw_raw = 1'b0;
        step(8);
        checks++; if (bus.doorclosed !== 1'b0 || bus.door_lock !== 1'b1) begin failures++; $display("FAIL lock_held_door_open: got door=%0b lock=%0b expected 0 1", bus.doorclosed, bus.door_lock); end
        bus.door_sw_raw = 1'b1;
        step(8);
        bus.program_done = 1'b1;
        step(1);
        bus.program_done = 1'b0;
        checks++; if (bus.door_lock !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL done_release: got lock=%0b busy=%0b expected 0 0", bus.door_lock, bus.busy); end
        checks++; if (bus.dbg_state !== ST_SELECT || bus.program_selection !== 3'd2) begin failures++; $display("FAIL done_state: got state=%0d sel=%0d expected %0d 2", bus.dbg_state, bus.program_selection, ST_SELECT); end
    endtask

    task automatic test_door_abort;
        logic start_seen = 1'b0;
        bus.btn_start_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == 2) bus.door_sw_raw = 1'b0;
            if (k == 7) bus.door_sw_raw = 1'b1;
            if (k == 10) bus.btn_start_raw = 1'b0;
            if (bus.start === 1'b1) start_seen = 1'b1;
            if (k == 7) begin
                checks++; if (bus.door_lock !== 1'b1) begin failures++; $display("FAIL abort_locking: got %0b expected 1", bus.door_lock); end
            end
            if (k == 9) begin
                checks++; if (bus.door_lock !== 1'b0 || bus.dbg_state !== ST_SELECT) begin failures++; $display("FAIL abort_release: got lock=%0b state=%0d expected 0 %0d", bus.door_lock, bus.dbg_state, ST_SELECT); end
            end
        end
        checks++; if (start_seen !== 1'b0) begin failures++; $display("FAIL abort_start: got %0b expected 0", start_seen); end
        step(10);
        checks++; if (bus.doorclosed !== 1'b1 || bus.dbg_state !== ST_SELECT) begin failures++; $display("FAIL abort_settle: got door=%0b state=%0d expected 1 %0d", bus.doorclosed, bus.dbg_state, ST_SELECT); end
    endtask

    task automatic test_power_priority;
        press(1);
        checks++; if (bus.dbg_state !== ST_RUNNING) begin failures++; $display("FAIL pwr_running: got %0d expected %0d", bus.dbg_state, ST_RUNNING); end
        bus.power = 1'b0;
        bus.program_done = 1'b1;
        step(1);
        checks++; if (bus.dbg_state !== ST_OFF || bus.program_selection !== 3'd0) begin failures++; $display("FAIL pwr_off: got state=%0d sel=%0d expected 0 0", bus.dbg_state, bus.program_selection); end
        checks++; if (bus.door_lock !== 1'b0 || bus.busy !== 1'b0 || bus.start !== 1'b0) begin failures++; $display("FAIL pwr_outputs: got lock=%0b busy=%0b start=%0b expected 0 0 0", bus.door_lock, bus.busy, bus.start); end
        bus.program_done = 1'b0;
        bus.power = 1'b1;
        step(1);
    endtask

    task automatic test_reset_mid_run;
        logic start_seen = 1'b0;
        press(0);
        checks++; if (bus.program_selection !== 3'd1) begin failures++; $display("FAIL rst_presel: got %0d expected 1", bus.program_selection); end
        press(1);
        checks++; if (bus.busy !== 1'b1 || bus.door_lock !== 1'b1) begin failures++; $display("FAIL rst_running: got busy=%0b lock=%0b expected 1 1", bus.busy, bus.door_lock); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.door_lock !== 1'b0 || bus.busy !== 1'b0 || bus.start !== 1'b0 || bus.program_selection !== 3'd0) begin failures++; $display("FAIL rst_async: got lock=%0b busy=%0b start=%0b sel=%0d expected 0 0 0 0", bus.door_lock, bus.busy, bus.start, bus.program_selection); end
        checks++; if (bus.dbg_state !== ST_OFF || bus.doorclosed !== 1'b0) begin failures++; $display("FAIL rst_state: got state=%0d door=%0b expected 0 0", bus.dbg_state, bus.doorclosed); end
        step(2);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (bus.start === 1'b1) start_seen = 1'b1;
        end
        checks++; if (start_seen !== 1'b0) begin failures++; $display("FAIL rst_no_start: got %0b expected 0", start_seen); end
        checks++; if (bus.dbg_state !== ST_SELECT || bus.door_lock !== 1'b0) begin failures++; $display("FAIL rst_recover: got state=%0d lock=%0b expected %0d 0", bus.dbg_state, bus.door_lock, ST_SELECT); end
    endtask

    initial begin
        bus.power         = 1'b0;
        bus.btn_prog_raw  = 1'b0;
        bus.btn_start_raw = 1'b0;
        bus.door_sw_raw   = 1'b0;
        bus.soap_sw_raw   = 1'b0;
        bus.program_done  = 1'b0;
        test_reset();
        test_soap();
        test_debounce_glitch();
        test_clean_press();
        test_wrap();
        test_start_door_open();
        test_start_run();
        test_door_abort();
        test_power_priority();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
